// File: rtl/usb_cdc_in_arbiter.sv
// ---------------------------------------------------------------------------
// usb_cdc_in_arbiter
// Round-robin arbiter that shares the usb_cdc device-to-host byte stream
// between NUM_REQ byte producers. A requester keeps the grant for a burst of
// at most MAX_BURST bytes, so bytes from different sources never interleave
// inside one USB packet. Runs entirely in the usb_cdc clock domain.
//
// Ports
//   clk_i          usb_cdc clock
//   rstn_i         asynchronous active-low reset
//   configured_i   arbitration enabled only while high
//   req_data_i     requester bytes, requester k on [8k+7:8k]
//   req_valid_i    requester byte valid
//   req_ready_o    requester byte accepted when valid & ready
//   in_data_o      byte to usb_cdc IN port
//   in_valid_o     byte valid to usb_cdc IN port
//   in_ready_i     usb_cdc IN port ready
//   grant_o        one-hot current grant, zero when idle
//   busy_o         high while a grant is held
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; outputs quiet; picks next requester after ptr
// GRANT | one requester connected to the IN port until burst/hold/unconfig
// ---------------------------------------------------------------------------
module usb_cdc_in_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int MAX_BURST   = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 configured_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           in_data_o,
    output logic                 in_valid_o,
    input  logic                 in_ready_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PTR_RESET  = PW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [HW-1:0]   idle_cnt_q, idle_cnt_d;

    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   cand;
    logic            sel_found;
    logic            gvalid;
    logic            xfer;

    // Round-robin search: first valid requester strictly after ptr, with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (!sel_found && req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign gvalid = req_valid_i[gidx_q];

    always_comb begin
        state_d     = state_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        req_ready_o = '0;
        in_data_o   = 8'h00;
        in_valid_o  = 1'b0;
        grant_o     = '0;
        busy_o      = 1'b0;
        xfer        = 1'b0;

        case (state_q)
            IDLE: begin
                if (configured_i && sel_found) begin
                    state_d     = GRANT;
                    gidx_d      = sel_idx;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end
            GRANT: begin
                busy_o      = 1'b1;
                grant_o     = NUM_REQ'(1) << gidx_q;
                in_valid_o  = gvalid;
                in_data_o   = req_data_i[{gidx_q, 3'b000} +: 8];
                req_ready_o = NUM_REQ'(in_ready_i) << gidx_q;
                xfer        = gvalid & in_ready_i;

                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                end
                idle_cnt_d = gvalid ? '0 : idle_cnt_q + HW'(1);

                // The byte that fills the burst still transfers this cycle;
                // the grant drops at the following edge.
                if ((xfer && (burst_cnt_q == BURST_LAST)) ||
                    (!gvalid && (idle_cnt_q == HOLD_LAST)) ||
                    !configured_i) begin
                    state_d     = IDLE;
                    ptr_d       = gidx_q;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            gidx_q      <= '0;
            ptr_q       <= PTR_RESET;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

endmodule
